// File: rtl/wm_panel.sv
// Washing-machine front panel: synchronizes and debounces the raw buttons and lid
// sensor, then runs the coin/credit/program-select FSM that drives the wash controller.

module wm_debounce #(
  parameter int DB = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_raw,
  input  logic i_level,
  output logic o_next
);
  logic [1:0] r_sync;
  logic [7:0] r_cnt;
  logic       w_mis;
  logic       w_flip;

  // The filtered level lives in the parent so it can see next/current together
  // and derive a press on the same edge the level rises.
  assign w_mis  = r_sync[1] ^ i_level;
  assign w_flip = w_mis && (r_cnt == 8'(DB - 1));
  assign o_next = w_flip ? r_sync[1] : i_level;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b00;
      r_cnt  <= 8'd0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (!w_mis || w_flip) r_cnt <= 8'd0;
      else                  r_cnt <= r_cnt + 8'd1;
    end
  end
endmodule

module wm_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COIN_PRICE      = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_coin_raw,
  input  logic       btn_cancel_raw,
  input  logic       btn_mode_raw,
  input  logic       btn_start_raw,
  input  logic       lid_raw,
  input  logic       idle,
  input  logic       ready,
  input  logic       coin_Return,
  output logic       coin,
  output logic       cancel,
  output logic       mode_1,
  output logic       mode_2,
  output logic       mode_3,
  output logic       lid,
  output logic [1:0] mode_sel,
  output logic [3:0] credit,
  output logic       refund_pulse,
  output logic [4:0] refund_count
);
  localparam int       NUM_IN = 5;
  localparam logic [3:0] PRICE = 4'(COIN_PRICE);

  typedef enum logic [1:0] {P_IDLE, P_COLLECT, P_ARMED, P_RUN} state_t;

  // lane order: 0 coin, 1 cancel, 2 mode, 3 start, 4 lid
  logic [NUM_IN-1:0] w_raw;
  logic [NUM_IN-1:0] w_next;
  logic [NUM_IN-1:0] r_lvl;
  logic [3:0]        w_press;

  assign w_raw = {lid_raw, btn_start_raw, btn_mode_raw, btn_cancel_raw, btn_coin_raw};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_db
      wm_debounce #(.DB(DEBOUNCE_CYCLES)) u_db (
        .clock   (clock),
        .reset_n (reset_n),
        .i_raw   (w_raw[gi]),
        .i_level (r_lvl[gi]),
        .o_next  (w_next[gi])
      );
    end
  endgenerate

  assign w_press = w_next[3:0] & ~r_lvl[3:0];

  state_t     r_state, w_nstate;
  logic [3:0] r_credit, w_ncredit, w_inc;
  logic [1:0] r_mode_sel, w_nmode_sel;
  logic       r_coin, w_ncoin;
  logic       r_cancel, w_ncancel;
  logic [2:0] r_modep, w_nmodep;
  logic       r_ref, w_nref;
  logic [4:0] r_ref_cnt, w_nref_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl      <= '0;
      r_state    <= P_IDLE;
      r_credit   <= 4'd0;
      r_mode_sel <= 2'd0;
      r_coin     <= 1'b0;
      r_cancel   <= 1'b0;
      r_modep    <= 3'b000;
      r_ref      <= 1'b0;
      r_ref_cnt  <= 5'd0;
    end else begin
      r_lvl      <= w_next;
      r_state    <= w_nstate;
      r_credit   <= w_ncredit;
      r_mode_sel <= w_nmode_sel;
      r_coin     <= w_ncoin;
      r_cancel   <= w_ncancel;
      r_modep    <= w_nmodep;
      r_ref      <= w_nref;
      r_ref_cnt  <= w_nref_cnt;
    end
  end

  always_comb begin
    w_inc       = r_credit;
    w_nstate    = r_state;
    w_nmode_sel = r_mode_sel;
    w_ncoin     = 1'b0;
    w_ncancel   = 1'b0;
    w_nmodep    = 3'b000;
    w_nref      = 1'b0;
    w_nref_cnt  = 5'd0;
    if (w_press[0] && r_credit != 4'd15) w_inc = r_credit + 4'd1;
    w_ncredit = w_inc;
    if (w_press[2] && r_state != P_RUN)
      w_nmode_sel = (r_mode_sel == 2'd2) ? 2'd0 : r_mode_sel + 2'd1;

    case (r_state)
      P_IDLE: begin
        if (w_press[0]) w_nstate = P_COLLECT;
      end
      P_COLLECT: begin
        if (w_press[1]) begin
          w_nref     = 1'b1;
          w_nref_cnt = {1'b0, w_inc};
          w_ncredit  = 4'd0;
          w_nstate   = P_IDLE;
        end else if (r_credit >= PRICE && idle) begin
          w_ncoin   = 1'b1;
          w_ncredit = w_inc - PRICE;
          w_nstate  = P_ARMED;
        end
      end
      P_ARMED, P_RUN: begin
        // controller-initiated return outranks every panel press this cycle
        if (coin_Return) begin
          w_nref     = 1'b1;
          w_nref_cnt = {1'b0, PRICE} + {1'b0, w_inc};
          w_ncredit  = 4'd0;
          w_nstate   = P_IDLE;
        end else if (w_press[1]) begin
          w_ncancel = 1'b1;
        end else if (r_state == P_ARMED) begin
          if (w_press[3] && ready) begin
            w_nmodep = 3'b001 << r_mode_sel;
            w_nstate = P_RUN;
          end
        end else if (idle) begin
          w_nstate = (w_inc != 4'd0) ? P_COLLECT : P_IDLE;
        end
      end
      default: w_nstate = P_IDLE;
    endcase
  end

  assign coin         = r_coin;
  assign cancel       = r_cancel;
  assign mode_1       = r_modep[0];
  assign mode_2       = r_modep[1];
  assign mode_3       = r_modep[2];
  assign lid          = r_lvl[4];
  assign mode_sel     = r_mode_sel;
  assign credit       = r_credit;
  assign refund_pulse = r_ref;
  assign refund_count = r_ref_cnt;
endmodule

// File: tb/tb_wm_panel.sv
// Randomized bench for wm_panel: clean button presses and controller status are applied
// as transactions and compared against an event-level model of the panel rules.

module tb_wm_panel;
  localparam int D     = 4;
  localparam int PRICE = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic btn_coin_raw = 0, btn_cancel_raw = 0, btn_mode_raw = 0, btn_start_raw = 0;
  logic lid_raw = 0, idle = 0, ready = 0, coin_Return = 0;
  logic coin, cancel, mode_1, mode_2, mode_3, lid, refund_pulse;
  logic [1:0] mode_sel;
  logic [3:0] credit;
  logic [4:0] refund_count;

  always #5 clock = ~clock;

  wm_panel #(.DEBOUNCE_CYCLES(D), .COIN_PRICE(PRICE)) dut (
    .clock(clock), .reset_n(reset_n),
    .btn_coin_raw(btn_coin_raw), .btn_cancel_raw(btn_cancel_raw),
    .btn_mode_raw(btn_mode_raw), .btn_start_raw(btn_start_raw),
    .lid_raw(lid_raw), .idle(idle), .ready(ready), .coin_Return(coin_Return),
    .coin(coin), .cancel(cancel), .mode_1(mode_1), .mode_2(mode_2), .mode_3(mode_3),
    .lid(lid), .mode_sel(mode_sel), .credit(credit),
    .refund_pulse(refund_pulse), .refund_count(refund_count)
  );

  int n_checks = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // output monitor: cumulative pulse counts
  int m_coin = 0, m_cancel = 0, m_ref = 0, m_multi = 0, m_rcbad = 0, m_last_rc = 0;
  int m_m1 = 0, m_m2 = 0, m_m3 = 0;
  always @(negedge clock) begin
    if (coin)   m_coin   <= m_coin + 1;
    if (cancel) m_cancel <= m_cancel + 1;
    if (mode_1) m_m1 <= m_m1 + 1;
    if (mode_2) m_m2 <= m_m2 + 1;
    if (mode_3) m_m3 <= m_m3 + 1;
    if (refund_pulse) begin
      m_ref     <= m_ref + 1;
      m_last_rc <= int'(refund_count);
    end else if (refund_count != 5'd0) m_rcbad <= m_rcbad + 1;
    if (int'(coin) + int'(cancel) + int'(mode_1) + int'(mode_2) + int'(mode_3) > 1)
      m_multi <= m_multi + 1;
  end

  // event-level reference model
  typedef enum {S_IDLE, S_COLLECT, S_ARMED, S_RUN} mst_t;
  mst_t ms = S_IDLE;
  int mc = 0, mm = 0;
  bit m_idle = 0, m_ready = 0;
  int e_coin, e_cancel, e_ref, e_rc;
  int e_m[3];

  task automatic settle();
    for (int k = 0; k < 4; k++) begin
      if (ms == S_COLLECT && mc >= PRICE && m_idle) begin
        e_coin++; mc -= PRICE; ms = S_ARMED;
      end else if (ms == S_RUN && m_idle) begin
        ms = (mc > 0) ? S_COLLECT : S_IDLE;
      end
    end
  endtask

  task automatic model_press(input bit pc, input bit pk, input bit pm, input bit ps, input bit pr);
    int inc, om;
    inc = pc ? ((mc < 15) ? mc + 1 : 15) : mc;
    om  = mm;
    if (pm && ms != S_RUN) mm = (mm + 1) % 3;
    case (ms)
      S_IDLE: if (pc) begin mc = 1; ms = S_COLLECT; end
      S_COLLECT: begin
        if (pk) begin e_ref++; e_rc = inc; mc = 0; ms = S_IDLE; end
        else if (mc >= PRICE && m_idle) begin e_coin++; mc = inc - PRICE; ms = S_ARMED; end
        else mc = inc;
      end
      default: begin
        if (pr) begin e_ref++; e_rc = PRICE + inc; mc = 0; ms = S_IDLE; end
        else begin
          mc = inc;
          if (pk) e_cancel++;
          else if (ms == S_ARMED) begin
            if (ps && m_ready) begin e_m[om]++; ms = S_RUN; end
          end else if (m_idle) ms = (mc > 0) ? S_COLLECT : S_IDLE;
        end
      end
    endcase
  endtask

  task automatic do_step(input bit si, input bit sr, input bit lr, input bit pc, input bit pk,
                         input bit pm, input bit ps, input bit pr, input string tag);
    int b_coin, b_cancel, b_ref, b_m1, b_m2, b_m3;
    b_coin = m_coin; b_cancel = m_cancel; b_ref = m_ref; b_m1 = m_m1; b_m2 = m_m2; b_m3 = m_m3;
    e_coin = 0; e_cancel = 0; e_ref = 0; e_rc = 0; e_m[0] = 0; e_m[1] = 0; e_m[2] = 0;
    @(negedge clock);
    idle = si; ready = sr; lid_raw = lr; m_idle = si; m_ready = sr;
    settle();
    repeat (4) @(negedge clock);
    btn_coin_raw = pc; btn_cancel_raw = pk; btn_mode_raw = pm; btn_start_raw = ps;
    repeat (D + 1) @(posedge clock);
    @(negedge clock);
    coin_Return = pr;
    @(posedge clock);
    @(negedge clock);
    coin_Return = 0;
    btn_coin_raw = 0; btn_cancel_raw = 0; btn_mode_raw = 0; btn_start_raw = 0;
    model_press(pc, pk, pm, ps, pr);
    settle();
    repeat (D + 6) @(negedge clock);
    chk({tag, " credit"}, int'(credit), mc);
    chk({tag, " mode_sel"}, int'(mode_sel), mm);
    chk({tag, " coin_pulses"}, m_coin - b_coin, e_coin);
    chk({tag, " cancel_pulses"}, m_cancel - b_cancel, e_cancel);
    chk({tag, " mode_pulses"}, (m_m1 - b_m1) + 4 * (m_m2 - b_m2) + 16 * (m_m3 - b_m3),
        e_m[0] + 4 * e_m[1] + 16 * e_m[2]);
    chk({tag, " refunds"}, m_ref - b_ref, e_ref);
    if (e_ref > 0) chk({tag, " refund_count"}, m_last_rc, e_rc);
    chk({tag, " lid"}, int'(lid), int'(lr));
  endtask

  initial begin
    int b_ref;
    repeat (3) @(negedge clock);
    chk("rst credit", int'(credit), 0);
    chk("rst pulses", int'({coin, cancel, mode_1, mode_2, mode_3, refund_pulse, lid}), 0);
    chk("rst mode_sel", int'(mode_sel), 0);
    reset_n = 1;

    // bouncing coin button: only the final stable level may count
    for (int i = 0; i < 10; i++) begin
      btn_coin_raw = ~btn_coin_raw;
      @(negedge clock);
    end
    btn_coin_raw = 1;
    repeat (D + 1) @(posedge clock);
    @(negedge clock);
    chk("bounce early", int'(credit), 0);
    @(posedge clock);
    @(negedge clock);
    chk("bounce credit", int'(credit), 1);
    btn_coin_raw = 0;
    ms = S_COLLECT; mc = 1;
    repeat (D + 6) @(negedge clock);

    lid_raw = 1;
    repeat (D + 1) @(posedge clock);
    @(negedge clock);
    chk("lid early", int'(lid), 0);
    @(posedge clock);
    @(negedge clock);
    chk("lid latency", int'(lid), 1);

    // two coins, arm, two mode presses, start -> third program
    do_step(0, 1, 1, 1, 0, 0, 0, 0, "r34 coin");
    do_step(1, 1, 1, 0, 0, 0, 0, 0, "r34 arm");
    do_step(0, 1, 1, 0, 0, 1, 0, 0, "r34 mode1");
    do_step(0, 1, 1, 0, 0, 1, 0, 0, "r34 mode2");
    do_step(0, 1, 1, 0, 0, 0, 1, 0, "r34 start");
    chk("r34 mode_3", m_m3, 1);
    // running, one coin, then return together with a coin
    do_step(0, 1, 1, 1, 0, 0, 0, 0, "r36 coin");
    do_step(0, 1, 1, 1, 0, 0, 0, 1, "r36 return");
    chk("r36 refund_count", m_last_rc, 4);
    // three coins then cancel
    for (int i = 0; i < 3; i++) do_step(0, 0, 1, 1, 0, 0, 0, 0, "r35 coin");
    do_step(0, 0, 1, 0, 1, 0, 0, 0, "r35 cancel");
    chk("r35 refund_count", m_last_rc, 3);
    // saturation
    for (int i = 0; i < 16; i++) do_step(0, 0, 1, 1, 0, 0, 0, 0, "r37 coin");
    chk("r37 sat", int'(credit), 15);
    do_step(1, 0, 1, 0, 0, 0, 0, 0, "r37 arm");
    chk("r37 credit", int'(credit), 13);

    // reset while armed, coin button held through reset
    b_ref = m_ref;
    @(negedge clock);
    reset_n = 0;
    btn_coin_raw = 1;
    #1;
    chk("r38 async credit", int'(credit), 0);
    chk("r38 async outs", int'({coin, cancel, mode_1, mode_2, mode_3, refund_pulse, lid, mode_sel, refund_count}), 0);
    @(negedge clock);
    reset_n = 1;
    ms = S_IDLE; mc = 0; mm = 0;
    repeat (D + 1) @(posedge clock);
    @(negedge clock);
    chk("r32 held early", int'(credit), 0);
    @(posedge clock);
    @(negedge clock);
    chk("r32 held press", int'(credit), 1);
    ms = S_COLLECT; mc = 1;
    btn_coin_raw = 0;
    repeat (D + 6) @(negedge clock);
    chk("r38 no refund", m_ref - b_ref, 0);

    for (int s = 0; s < 80; s++) begin
      do_step(bit'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, bit'($urandom_range(0, 1)),
              $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 2, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) < 4, $urandom_range(0, 19) < 3, "rand");
    end

    chk("pulse exclusivity", m_multi, 0);
    chk("refund_count idle zero", m_rcbad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
